// File: rtl/cook_sequencer.sv
// Microwave cook sequencer: keypad digit buffer, start/stop/clear handling,
// 1 Hz prescaler for the external countdown and the end-of-cook beep timer.
module cook_sequencer #(
  parameter int CLK_HZ    = 100,
  parameter int BEEP_SECS = 3
) (
  input  logic       clk,
  input  logic       resetn,
  input  logic       startn,
  input  logic       stopn,
  input  logic       clearn,
  input  logic       door_closed,
  input  logic       key_valid,
  input  logic [3:0] key_digit,
  input  logic       timer_zero,
  output logic       load_en,
  output logic [3:0] load_min,
  output logic [3:0] load_sec_tens,
  output logic [3:0] load_sec_ones,
  output logic       count_en,
  output logic       tick_1hz,
  output logic       mag_on,
  output logic       beep,
  output logic [2:0] state
);

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    ENTRY = 3'd1,
    COOK  = 3'd2,
    PAUSE = 3'd3,
    DONE  = 3'd4
  } state_t;

  localparam int BEEP_CYCLES = BEEP_SECS * CLK_HZ;
  localparam int PW = $clog2(CLK_HZ + 1);
  localparam int BW = $clog2(BEEP_CYCLES + 1);
  localparam logic [PW-1:0] PRESC_LAST = PW'(CLK_HZ - 1);
  localparam logic [BW-1:0] BEEP_LAST  = BW'(BEEP_CYCLES - 1);

  state_t        cur_state;
  state_t        next_state;
  logic [3:0]    buf_min;
  logic [3:0]    buf_tens;
  logic [3:0]    buf_ones;
  logic [PW-1:0] presc;
  logic [BW-1:0] beep_cnt;
  logic          start_prev;
  logic          start_evt;
  logic          start_ok;
  logic          key_shift;
  logic          accept_load;
  logic          clear_all;
  logic          done_exit;

  assign start_evt = start_prev & ~startn;
  assign start_ok  = door_closed && ({buf_min, buf_tens, buf_ones} != 12'd0) && (buf_tens <= 4'd5);
  assign state     = cur_state;

  // Next-state decode; clear beats everything, then timer/door/stop/start/key in that order
  always_comb begin
    next_state  = cur_state;
    key_shift   = 1'b0;
    accept_load = 1'b0;
    clear_all   = 1'b0;
    done_exit   = 1'b0;
    if (!clearn) begin
      next_state = IDLE;
      clear_all  = 1'b1;
    end else begin
      case (cur_state)
        IDLE: begin
          if (key_valid) begin
            key_shift  = 1'b1;
            next_state = ENTRY;
          end
        end
        ENTRY: begin
          if (start_evt) begin
            if (start_ok) begin
              accept_load = 1'b1;
              next_state  = COOK;
            end
          end else if (key_valid) begin
            key_shift = 1'b1;
          end
        end
        COOK: begin
          if (timer_zero) begin
            next_state = DONE;
          end else if (!door_closed || !stopn) begin
            next_state = PAUSE;
          end
        end
        PAUSE: begin
          if (door_closed && stopn && start_evt) begin
            next_state = COOK;
          end
        end
        DONE: begin
          if (beep_cnt == BEEP_LAST) begin
            next_state = IDLE;
            done_exit  = 1'b1;
          end
        end
        default: next_state = IDLE;
      endcase
    end
  end

  // State register
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) cur_state <= IDLE;
    else         cur_state <= next_state;
  end

  // Previous startn level for falling-edge start detection
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) start_prev <= 1'b1;
    else         start_prev <= startn;
  end

  // Keypad digit buffer, shifts left on each accepted digit
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      buf_min  <= 4'd0;
      buf_tens <= 4'd0;
      buf_ones <= 4'd0;
    end else if (clear_all || done_exit) begin
      buf_min  <= 4'd0;
      buf_tens <= 4'd0;
      buf_ones <= 4'd0;
    end else if (key_shift) begin
      buf_min  <= buf_tens;
      buf_tens <= buf_ones;
      buf_ones <= key_digit;
    end
  end

  // Prescaler counts cycles spent cooking and holds its value across a pause
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      presc <= '0;
    end else if (clear_all || accept_load) begin
      presc <= '0;
    end else if (next_state == COOK) begin
      presc <= (presc == PRESC_LAST) ? '0 : presc + 1'b1;
    end
  end

  // Beep duration counter, only runs while staying in DONE
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      beep_cnt <= '0;
    end else if (cur_state == DONE && next_state == DONE) begin
      beep_cnt <= beep_cnt + 1'b1;
    end else begin
      beep_cnt <= '0;
    end
  end

  // Registered outputs derived from the upcoming state
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      load_en       <= 1'b0;
      load_min      <= 4'd0;
      load_sec_tens <= 4'd0;
      load_sec_ones <= 4'd0;
      count_en      <= 1'b0;
      tick_1hz      <= 1'b0;
      mag_on        <= 1'b0;
      beep          <= 1'b0;
    end else begin
      load_en       <= accept_load;
      load_min      <= accept_load ? buf_min  : 4'd0;
      load_sec_tens <= accept_load ? buf_tens : 4'd0;
      load_sec_ones <= accept_load ? buf_ones : 4'd0;
      count_en      <= (next_state == COOK);
      mag_on        <= (next_state == COOK);
      tick_1hz      <= (next_state == COOK) && !accept_load && (presc == PRESC_LAST);
      beep          <= (next_state == DONE);
    end
  end

endmodule

// File: tb/tb_cook_sequencer.sv
// Directed bench for cook_sequencer with CLK_HZ=10, BEEP_SECS=2.
module tb_cook_sequencer;

  logic       clk = 1'b0;
  logic       resetn;
  logic       startn, stopn, clearn, door_closed, key_valid, timer_zero;
  logic [3:0] key_digit;
  logic       load_en, count_en, tick_1hz, mag_on, beep;
  logic [3:0] load_min, load_sec_tens, load_sec_ones;
  logic [2:0] state;

  int n_compared   = 0;
  int n_mismatched = 0;

  typedef struct {
    logic        sn, sp, cl, dr, kv;
    logic [3:0]  kd;
    logic        tz;
    logic [2:0]  e_state;
    logic        e_load_en;
    logic [11:0] e_load;
    logic        e_mag;
    logic        e_beep;
  } vec_t;

  vec_t vecs[$];

  cook_sequencer #(.CLK_HZ(10), .BEEP_SECS(2)) dut (
    .clk(clk), .resetn(resetn), .startn(startn), .stopn(stopn), .clearn(clearn),
    .door_closed(door_closed), .key_valid(key_valid), .key_digit(key_digit),
    .timer_zero(timer_zero), .load_en(load_en), .load_min(load_min),
    .load_sec_tens(load_sec_tens), .load_sec_ones(load_sec_ones),
    .count_en(count_en), .tick_1hz(tick_1hz), .mag_on(mag_on), .beep(beep),
    .state(state)
  );

  // 10 time-unit clock
  always #5 clk = ~clk;

  function automatic vec_t mk(input logic sn, sp, cl, dr, kv, input logic [3:0] kd,
                              input logic tz, input logic [2:0] st, input logic le,
                              input logic [11:0] ld, input logic mg, bp);
    vec_t v;
    v.sn = sn; v.sp = sp; v.cl = cl; v.dr = dr; v.kv = kv; v.kd = kd; v.tz = tz;
    v.e_state = st; v.e_load_en = le; v.e_load = ld; v.e_mag = mg; v.e_beep = bp;
    return v;
  endfunction

  task automatic checkOutput(input string name, input int act, input int exp);
    n_compared++;
    if (act != exp) begin
      n_mismatched++;
      $display("[TB] FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic applyStimulus(input vec_t v);
    startn = v.sn; stopn = v.sp; clearn = v.cl; door_closed = v.dr;
    key_valid = v.kv; key_digit = v.kd; timer_zero = v.tz;
  endtask

  task automatic idleInputs();
    startn = 1'b1; stopn = 1'b1; clearn = 1'b1; door_closed = 1'b1;
    key_valid = 1'b0; key_digit = 4'd0; timer_zero = 1'b0;
  endtask

  task automatic stepCycle();
    @(posedge clk);
    #1;
  endtask

  task automatic pressKey(input logic [3:0] d);
    key_valid = 1'b1; key_digit = d;
    stepCycle();
    key_valid = 1'b0; key_digit = 4'd0;
  endtask

  // Counts cycles until tick_1hz is seen, noting any load_en on the way
  task automatic waitTick(output int n, output logic saw_load);
    n = 0; saw_load = 1'b0;
    while (n < 30) begin
      stepCycle();
      n++;
      if (load_en) saw_load = 1'b1;
      if (tick_1hz) break;
    end
  endtask

  initial begin
    int gap;
    logic saw_load;
    int beep_len;

    // Table: sn sp cl dr kv kd tz | state load_en load mag beep
    vecs.push_back(mk(1,1,1,1,1,4'd0,0, 3'd1,0,12'h000,0,0));
    vecs.push_back(mk(1,1,1,1,1,4'd7,0, 3'd1,0,12'h000,0,0));
    vecs.push_back(mk(1,1,1,1,1,4'd5,0, 3'd1,0,12'h000,0,0));
    vecs.push_back(mk(0,1,1,1,0,4'd0,0, 3'd1,0,12'h000,0,0));
    vecs.push_back(mk(1,1,1,1,0,4'd0,0, 3'd1,0,12'h000,0,0));
    vecs.push_back(mk(1,1,0,1,0,4'd0,0, 3'd0,0,12'h000,0,0));
    vecs.push_back(mk(1,1,1,1,1,4'd1,0, 3'd1,0,12'h000,0,0));
    vecs.push_back(mk(1,1,1,1,1,4'd3,0, 3'd1,0,12'h000,0,0));
    vecs.push_back(mk(1,1,1,1,1,4'd0,0, 3'd1,0,12'h000,0,0));
    vecs.push_back(mk(0,1,1,0,0,4'd0,0, 3'd1,0,12'h000,0,0));
    vecs.push_back(mk(1,1,1,1,0,4'd0,0, 3'd1,0,12'h000,0,0));
    vecs.push_back(mk(0,1,1,1,1,4'd9,0, 3'd2,1,12'h130,1,0));
    vecs.push_back(mk(0,1,1,1,0,4'd0,0, 3'd2,0,12'h000,1,0));
    vecs.push_back(mk(1,1,1,1,1,4'd4,0, 3'd2,0,12'h000,1,0));
    vecs.push_back(mk(1,0,1,1,0,4'd0,0, 3'd3,0,12'h000,0,0));
    vecs.push_back(mk(0,1,1,0,0,4'd0,0, 3'd3,0,12'h000,0,0));
    vecs.push_back(mk(1,1,1,1,0,4'd0,0, 3'd3,0,12'h000,0,0));
    vecs.push_back(mk(0,1,1,1,0,4'd0,0, 3'd2,0,12'h000,1,0));
    vecs.push_back(mk(1,0,1,1,0,4'd0,1, 3'd4,0,12'h000,0,1));
    vecs.push_back(mk(1,1,1,1,0,4'd0,0, 3'd4,0,12'h000,0,1));
    vecs.push_back(mk(1,1,0,1,0,4'd0,0, 3'd0,0,12'h000,0,0));
    vecs.push_back(mk(1,1,1,1,1,4'd2,0, 3'd1,0,12'h000,0,0));
    vecs.push_back(mk(0,1,1,1,0,4'd0,0, 3'd2,1,12'h002,1,0));
    vecs.push_back(mk(1,1,0,0,0,4'd0,1, 3'd0,0,12'h000,0,0));
    vecs.push_back(mk(1,1,1,1,1,4'd6,0, 3'd1,0,12'h000,0,0));
    vecs.push_back(mk(0,1,0,1,0,4'd0,0, 3'd0,0,12'h000,0,0));
    vecs.push_back(mk(1,1,1,1,1,4'd5,0, 3'd1,0,12'h000,0,0));
    vecs.push_back(mk(0,1,1,1,0,4'd0,0, 3'd2,1,12'h005,1,0));
    vecs.push_back(mk(1,1,0,1,0,4'd0,0, 3'd0,0,12'h000,0,0));
    vecs.push_back(mk(1,1,1,1,1,4'd5,0, 3'd1,0,12'h000,0,0));
    vecs.push_back(mk(1,1,1,1,1,4'd9,0, 3'd1,0,12'h000,0,0));
    vecs.push_back(mk(0,1,1,1,0,4'd0,0, 3'd2,1,12'h059,1,0));
    vecs.push_back(mk(1,1,0,1,0,4'd0,0, 3'd0,0,12'h000,0,0));
    vecs.push_back(mk(1,1,1,1,1,4'd0,0, 3'd1,0,12'h000,0,0));
    vecs.push_back(mk(0,1,1,1,0,4'd0,0, 3'd1,0,12'h000,0,0));
    vecs.push_back(mk(1,1,0,1,0,4'd0,0, 3'd0,0,12'h000,0,0));
    vecs.push_back(mk(1,1,1,1,1,4'd1,0, 3'd1,0,12'h000,0,0));
    vecs.push_back(mk(1,1,1,1,1,4'd2,0, 3'd1,0,12'h000,0,0));
    vecs.push_back(mk(1,1,1,1,1,4'd3,0, 3'd1,0,12'h000,0,0));
    vecs.push_back(mk(1,1,1,1,1,4'd4,0, 3'd1,0,12'h000,0,0));
    vecs.push_back(mk(0,1,1,1,0,4'd0,0, 3'd2,1,12'h234,1,0));
    vecs.push_back(mk(1,1,0,1,0,4'd0,0, 3'd0,0,12'h000,0,0));

    // Reset state
    resetn = 1'b0;
    idleInputs();
    repeat (2) @(posedge clk);
    #1;
    checkOutput("reset_state", int'(state), 0);
    checkOutput("reset_mag_on", int'(mag_on), 0);
    checkOutput("reset_load_en", int'(load_en), 0);
    checkOutput("reset_beep", int'(beep), 0);
    checkOutput("reset_count_en", int'(count_en), 0);
    @(negedge clk);
    resetn = 1'b1;

    // Table-driven single-cycle vectors
    for (int i = 0; i < vecs.size(); i++) begin
      applyStimulus(vecs[i]);
      stepCycle();
      checkOutput($sformatf("vec%0d_state", i), int'(state), int'(vecs[i].e_state));
      checkOutput($sformatf("vec%0d_load_en", i), int'(load_en), int'(vecs[i].e_load_en));
      if (vecs[i].e_load_en)
        checkOutput($sformatf("vec%0d_load", i),
                    int'({load_min, load_sec_tens, load_sec_ones}), int'(vecs[i].e_load));
      checkOutput($sformatf("vec%0d_mag_on", i), int'(mag_on), int'(vecs[i].e_mag));
      checkOutput($sformatf("vec%0d_count_en", i), int'(count_en), int'(vecs[i].e_mag));
      checkOutput($sformatf("vec%0d_beep", i), int'(beep), int'(vecs[i].e_beep));
      checkOutput($sformatf("vec%0d_tick", i), int'(tick_1hz), 0);
    end
    idleInputs();
    stepCycle();

    // Keys 1,3,0 then start: load 1:30 and a tick every 10 cycles
    pressKey(4'd1); pressKey(4'd3); pressKey(4'd0);
    startn = 1'b0;
    stepCycle();
    startn = 1'b1;
    checkOutput("cook_load_en", int'(load_en), 1);
    checkOutput("cook_load_val", int'({load_min, load_sec_tens, load_sec_ones}), 'h130);
    checkOutput("cook_mag_on", int'(mag_on), 1);
    waitTick(gap, saw_load);
    checkOutput("first_tick_gap", gap, 10);
    stepCycle();
    checkOutput("tick_one_cycle", int'(tick_1hz), 0);
    waitTick(gap, saw_load);
    checkOutput("second_tick_gap", gap, 9);

    // Door opened 4 cycles after a tick, then closed and resumed
    repeat (3) @(posedge clk);
    #1;
    door_closed = 1'b0;
    stepCycle();
    checkOutput("pause_state", int'(state), 3);
    checkOutput("pause_mag_on", int'(mag_on), 0);
    checkOutput("pause_count_en", int'(count_en), 0);
    stepCycle();
    stepCycle();
    door_closed = 1'b1;
    stepCycle();
    checkOutput("pause_hold_state", int'(state), 3);
    startn = 1'b0;
    stepCycle();
    startn = 1'b1;
    checkOutput("resume_state", int'(state), 2);
    checkOutput("resume_mag_on", int'(mag_on), 1);
    checkOutput("resume_load_en", int'(load_en), 0);
    waitTick(gap, saw_load);
    checkOutput("resume_tick_gap", gap, 6);
    checkOutput("resume_no_load", int'(saw_load), 0);

    // timer_zero -> DONE, beep for 20 cycles, then IDLE with empty buffer
    stepCycle();
    timer_zero = 1'b1;
    stepCycle();
    timer_zero = 1'b0;
    checkOutput("done_state", int'(state), 4);
    checkOutput("done_mag_on", int'(mag_on), 0);
    beep_len = 0;
    while (beep && beep_len < 40) begin
      beep_len++;
      stepCycle();
    end
    checkOutput("beep_length", beep_len, 20);
    checkOutput("after_done_state", int'(state), 0);
    pressKey(4'd7);
    startn = 1'b0;
    stepCycle();
    startn = 1'b1;
    checkOutput("after_done_load", int'({load_min, load_sec_tens, load_sec_ones}), 'h007);
    checkOutput("after_done_load_en", int'(load_en), 1);

    // Asynchronous reset mid-cook
    repeat (3) stepCycle();
    checkOutput("pre_reset_mag_on", int'(mag_on), 1);
    @(negedge clk);
    resetn = 1'b0;
    #1;
    checkOutput("async_reset_mag_on", int'(mag_on), 0);
    checkOutput("async_reset_state", int'(state), 0);
    @(negedge clk);
    resetn = 1'b1;
    stepCycle();
    checkOutput("post_reset_state", int'(state), 0);
    checkOutput("post_reset_mag_on", int'(mag_on), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_compared, n_mismatched);
    $finish;
  end

endmodule
